// File: rtl/network_scheduler.sv
// Sequences one spiking-network inference per host request: capture a pattern,
// clear the network, observe neuron_out for a fixed window, report the spike count.
module network_scheduler #(
  parameter int unsigned HEIGHT       = 7,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned THRESH       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HEIGHT-1:0] in_pixels,
  output logic [HEIGHT-1:0] pixels,
  output logic              net_rst,
  input  logic              neuron_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_fire,
  output logic              busy
);

  localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;

  state_t             state, state_n;
  logic [CLR_W-1:0]   clr_cnt, clr_cnt_n;
  logic [WIN_W-1:0]   win_cnt, win_cnt_n;
  logic [CNT_W-1:0]   spk_cnt, spk_cnt_n;
  logic               nrn_q, nrn_q_n;
  logic [HEIGHT-1:0]  pixels_n;
  logic               net_rst_n, in_ready_n, res_valid_n, res_fire_n, busy_n;
  logic [CNT_W-1:0]   res_count_n;

  // Next-state and next-output logic; every register holds unless overridden.
  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    win_cnt_n   = win_cnt;
    spk_cnt_n   = spk_cnt;
    nrn_q_n     = nrn_q;
    pixels_n    = pixels;
    net_rst_n   = net_rst;
    in_ready_n  = in_ready;
    res_valid_n = res_valid;
    res_count_n = res_count;
    res_fire_n  = res_fire;
    busy_n      = busy;

    unique case (state)
      IDLE: begin
        in_ready_n = 1'b1;
        net_rst_n  = 1'b0;
        if (in_valid && in_ready) begin
          pixels_n   = in_pixels;
          in_ready_n = 1'b0;
          clr_cnt_n  = '0;
          spk_cnt_n  = '0;
          nrn_q_n    = 1'b0;
          busy_n     = 1'b1;
          state_n    = CLEAR;
        end
      end
      CLEAR: begin
        clr_cnt_n = clr_cnt + CLR_W'(1);
        if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
          net_rst_n = 1'b1;
          win_cnt_n = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        nrn_q_n   = neuron_out;
        win_cnt_n = win_cnt + WIN_W'(1);
        if (neuron_out && !nrn_q && (spk_cnt != CNT_MAX)) begin
          spk_cnt_n = spk_cnt + CNT_W'(1);
        end
        // The final edge's sample is already folded into spk_cnt_n.
        if (win_cnt == WIN_W'(WINDOW - 1)) begin
          net_rst_n   = 1'b0;
          res_count_n = spk_cnt_n;
          res_fire_n  = (32'(spk_cnt_n) >= THRESH);
          res_valid_n = 1'b1;
          busy_n      = 1'b0;
          state_n     = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      win_cnt   <= '0;
      spk_cnt   <= '0;
      nrn_q     <= 1'b0;
      pixels    <= '0;
      net_rst   <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_fire  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      clr_cnt   <= clr_cnt_n;
      win_cnt   <= win_cnt_n;
      spk_cnt   <= spk_cnt_n;
      nrn_q     <= nrn_q_n;
      pixels    <= pixels_n;
      net_rst   <= net_rst_n;
      in_ready  <= in_ready_n;
      res_valid <= res_valid_n;
      res_count <= res_count_n;
      res_fire  <= res_fire_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_network_scheduler.sv
// Directed bench for network_scheduler: a CNT_W=4 and a CNT_W=3 instance share stimulus.
module tb_network_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       neuron_out = 1'b0;
  logic [6:0] in_pixels = '0;

  logic       a_in_ready, a_net_rst, a_res_valid, a_res_fire, a_busy;
  logic [6:0] a_pixels;
  logic [3:0] a_res_count;
  logic       b_in_ready, b_net_rst, b_res_valid, b_res_fire, b_busy;
  logic [6:0] b_pixels;
  logic [2:0] b_res_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  network_scheduler #(.HEIGHT(7), .CLEAR_CYCLES(2), .WINDOW(16), .CNT_W(4), .THRESH(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_pixels(in_pixels),
    .pixels(a_pixels), .net_rst(a_net_rst), .neuron_out(neuron_out), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_count(a_res_count), .res_fire(a_res_fire), .busy(a_busy));

  network_scheduler #(.HEIGHT(7), .CLEAR_CYCLES(2), .WINDOW(16), .CNT_W(3), .THRESH(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pixels(in_pixels),
    .pixels(b_pixels), .net_rst(b_net_rst), .neuron_out(neuron_out), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_count(b_res_count), .res_fire(b_res_fire), .busy(b_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({a_in_ready, a_net_rst, a_res_valid, a_res_fire, a_busy, a_pixels, a_res_count,
                b_in_ready, b_net_rst, b_res_valid, b_res_fire, b_busy, b_pixels, b_res_count});
  endfunction

  // One request; pat[k] is neuron_out during RUN cycle k, noise elsewhere.
  task automatic do_txn(input logic [6:0] p, input logic [15:0] pat, input logic noise,
                        input logic hold_ready, input int abort_n);
    int  n = 0;
    int  nrst = 0;
    bit  done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_pixels = p; res_ready = hold_ready; neuron_out = noise;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      in_valid = 1'b0;
      if (n == 1) begin
        check("accept_pixels", 32'(a_pixels), 32'(p));
        check("accept_busy", 32'(a_busy), 32'd1);
        check("accept_in_ready", 32'(a_in_ready), 32'd0);
      end
      if (a_res_valid) begin
        done = 1'b1;
        check("latency", 32'(n - 1), 32'd18);
        check("net_rst_cycles", 32'(nrst), 32'd16);
        check("res_valid_b", 32'(b_res_valid), 32'd1);
      end else begin
        if (a_net_rst) nrst++;
        if (n == abort_n) begin
          rst = 1'b0;
          #1;
          check("abort_outputs", all_outs(), 32'd0);
          done = 1'b1;
        end else begin
          neuron_out = (n >= 3 && n <= 18) ? pat[n-3] : noise;
        end
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  // Check the result, stall the host for `hold` cycles, then complete the handshake.
  task automatic finish_txn(input int hold, input logic [3:0] ca, input logic fa,
                            input logic [2:0] cb, input logic fb);
    check("count_a", 32'(a_res_count), 32'(ca));
    check("fire_a", 32'(a_res_fire), 32'(fa));
    check("count_b", 32'(b_res_count), 32'(cb));
    check("fire_b", 32'(b_res_fire), 32'(fb));
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      in_valid = (i == 2);
      neuron_out = i[0];
      @(negedge clk);
      check("hold_valid", 32'(a_res_valid), 32'd1);
      check("hold_count", 32'(a_res_count), 32'(ca));
      check("hold_in_ready", 32'(a_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("release_valid", 32'(a_res_valid), 32'd0);
    check("release_in_ready", 32'(a_in_ready), 32'd1);
    check("release_busy", 32'(a_busy), 32'd0);
    check("release_count_kept", 32'(a_res_count), 32'(ca));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    #1 check("in_ready_before_edge", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", 32'(a_in_ready), 32'd1);
    check("idle_pixels", 32'(a_pixels), 32'd0);
    check("idle_net_rst", 32'(a_net_rst), 32'd0);

    // three isolated pulses, host stalls five cycles with an ignored in_valid
    do_txn(7'b0101010, 16'h0222, 1'b0, 1'b0, 0);
    finish_txn(5, 4'd3, 1'b1, 3'd3, 1'b1);

    // held high through RUN, noise in CLEAR, res_ready high across REPORT entry
    do_txn(7'b1111111, 16'hFFFF, 1'b1, 1'b1, 0);
    finish_txn(0, 4'd1, 1'b0, 3'd1, 1'b0);

    // eight rising edges: saturates the 3-bit counter only
    do_txn(7'b0000001, 16'h5555, 1'b0, 1'b0, 0);
    finish_txn(0, 4'd8, 1'b1, 3'd7, 1'b1);

    // abort at RUN cycle 8, then a normal request
    do_txn(7'b1100110, 16'hFFFF, 1'b0, 1'b0, 11);
    repeat (2) @(negedge clk);
    check("abort_no_valid", 32'(a_res_valid), 32'd0);
    check("abort_not_busy", 32'(a_busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(a_in_ready), 32'd1);
    do_txn(7'b0101010, 16'h0222, 1'b0, 1'b0, 0);
    finish_txn(0, 4'd3, 1'b1, 3'd3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
